// File: rtl/seq_detect_session_ctrl.sv
// Serial pattern detection session controller: the host loads a pattern, a match target and a
// timeout, then streams bits in; occurrences are counted until target, timeout or abort.
module seq_detect_session_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    input  logic               abort,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    input  logic               done_ack
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // ready depends only on the FSM state, never on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [TMO_W-1:0]   timeout_q, timeout_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-2:0] window_q, window_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               timed_out_q, timed_out_d;
    logic               detected_q, detected_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] new_window;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic [CNT_W-1:0]   count_inc;
    logic               len_legal;
    logic               accept;
    logic               match;
    logic               target_hit;
    logic               timeout_hit;

    assign cfg_ready   = (state_q == IDLE);
    assign in_ready    = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign detected    = detected_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = count_q;
    assign timed_out   = timed_out_q;

    assign len_legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept      = in_valid && (state_q == RUN);
    assign new_window  = {window_q, in_bit};
    assign fill_inc    = (LEN_W+1)'(fill_q) + (LEN_W+1)'(1);
    assign count_inc   = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    // Only the newest len bits of the window take part in the comparison.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign match       = accept && (fill_inc >= (LEN_W+1)'(len_q)) &&
                         (((new_window ^ pattern_q) & len_mask) == '0);
    assign target_hit  = match && (target_q != '0) && (count_inc == target_q);
    assign timeout_hit = (timeout_q != '0) && (timer_q == timeout_q - TMO_W'(1));

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        target_d    = target_q;
        timeout_d   = timeout_q;
        overlap_d   = overlap_q;
        window_d    = window_q;
        fill_d      = fill_q;
        timer_d     = timer_q;
        count_d     = count_q;
        timed_out_d = timed_out_q;
        detected_d  = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (len_legal) begin
                        pattern_d   = cfg_pattern;
                        len_d       = cfg_len;
                        target_d    = cfg_target;
                        timeout_d   = cfg_timeout;
                        overlap_d   = cfg_overlap;
                        window_d    = '0;
                        fill_d      = '0;
                        timer_d     = '0;
                        count_d     = '0;
                        timed_out_d = 1'b0;
                        state_d     = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                    if (accept) begin
                        window_d = new_window[MAX_LEN-2:0];
                        if (match && !overlap_q) begin
                            fill_d = '0;
                        end else if (fill_inc >= (LEN_W+1)'(len_q)) begin
                            fill_d = len_q;
                        end else begin
                            fill_d = fill_inc[LEN_W-1:0];
                        end
                    end
                    if (match) begin
                        detected_d = 1'b1;
                        count_d    = count_inc;
                    end
                    // A target reached on the final timeout cycle counts as a normal finish.
                    if (target_hit) begin
                        timed_out_d = 1'b0;
                        state_d     = DONE;
                    end else if (timeout_hit) begin
                        timed_out_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            DONE: begin
                if (done_ack || abort) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            target_q    <= '0;
            timeout_q   <= '0;
            overlap_q   <= 1'b0;
            window_q    <= '0;
            fill_q      <= '0;
            timer_q     <= '0;
            count_q     <= '0;
            timed_out_q <= 1'b0;
            detected_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            target_q    <= target_d;
            timeout_q   <= timeout_d;
            overlap_q   <= overlap_d;
            window_q    <= window_d;
            fill_q      <= fill_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            timed_out_q <= timed_out_d;
            detected_q  <= detected_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_session_ctrl.sv
// Directed bench for seq_detect_session_ctrl: a table of whole-session vectors over one
// reference stream, then hand-written sequences for stalls, abort, illegal config and reset.
module tb_seq_detect_session_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        cfg_overlap;
    logic        cfg_err;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        abort;
    logic        detected;
    logic [7:0]  match_count;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        done_ack;

    int checks = 0;
    int errors = 0;

    seq_detect_session_ctrl #(
        .MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TMO_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .abort(abort),
        .detected(detected), .match_count(match_count), .busy(busy), .done(done),
        .timed_out(timed_out), .done_ack(done_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic        overlap;
        logic [7:0]  target;
        logic [15:0] timeout;
        logic [23:0] exp_mask;   // bit i set: detected after stream bit i
        int          exp_acc;
        logic [7:0]  exp_count;
        logic        exp_done;
        logic        exp_to;
    } vec_t;

    vec_t        vecs[7];
    logic [23:0] stream_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                          input logic [7:0] t, input logic [15:0] tmo);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_target  = t;
        cfg_timeout = tmo;
        cfg_valid   = 1'b1;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    // Stream bits idx 0..23 back to back while the block is accepting.
    task automatic run_stream(output logic [23:0] mask, output int acc);
        mask = '0;
        acc  = 0;
        for (int i = 0; i < 24; i++) begin
            if (!in_ready) break;
            in_valid = 1'b1;
            in_bit   = stream_v[23-i];
            @(negedge clk);
            acc++;
            if (detected) mask[i] = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [23:0] mask;
        int          acc;
        int          done_cycle;
        logic        last_det;

        rst = 1'b1;
        cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_target = 0; cfg_timeout = 0;
        cfg_overlap = 0; in_valid = 0; in_bit = 0; abort = 0; done_ack = 0;
        stream_v = 24'b0011_0101_1001_1001_1010_1000;

        vecs[0] = '{8'b110011, 4'd6, 1'b1, 8'd0, 16'd0,  24'h011000, 24, 8'd2, 1'b0, 1'b0};
        vecs[1] = '{8'b110011, 4'd6, 1'b0, 8'd0, 16'd0,  24'h001000, 24, 8'd1, 1'b0, 1'b0};
        vecs[2] = '{8'b1010,   4'd4, 1'b1, 8'd0, 16'd0,  24'h280040, 24, 8'd3, 1'b0, 1'b0};
        vecs[3] = '{8'b1010,   4'd4, 1'b0, 8'd0, 16'd0,  24'h080040, 24, 8'd2, 1'b0, 1'b0};
        vecs[4] = '{8'b1010,   4'd4, 1'b1, 8'd2, 16'd0,  24'h080040, 20, 8'd2, 1'b1, 1'b0};
        vecs[5] = '{8'b110011, 4'd6, 1'b1, 8'd0, 16'd14, 24'h001000, 14, 8'd1, 1'b1, 1'b1};
        vecs[6] = '{8'b110011, 4'd6, 1'b1, 8'd1, 16'd13, 24'h001000, 13, 8'd1, 1'b1, 1'b0};

        #1;
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_detected", 32'(detected), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            chk($sformatf("v%0d_cfg_ready", v), 32'(cfg_ready), 1);
            do_cfg(vecs[v].pattern, vecs[v].len, vecs[v].overlap, vecs[v].target,
                   vecs[v].timeout);
            chk($sformatf("v%0d_busy_start", v), 32'(busy), 1);
            run_stream(mask, acc);
            chk($sformatf("v%0d_det_mask", v), 32'(mask), 32'(vecs[v].exp_mask));
            chk($sformatf("v%0d_accepted", v), 32'(acc), 32'(vecs[v].exp_acc));
            chk($sformatf("v%0d_count", v), 32'(match_count), 32'(vecs[v].exp_count));
            chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(!vecs[v].exp_done));
            if (vecs[v].exp_done) begin
                chk($sformatf("v%0d_timed_out", v), 32'(timed_out), 32'(vecs[v].exp_to));
                done_ack = 1'b1;
                @(negedge clk);
                done_ack = 1'b0;
            end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            chk($sformatf("v%0d_idle", v), 32'({cfg_ready, busy, done}), 32'(3'b100));
            chk($sformatf("v%0d_count_hold", v), 32'(match_count), 32'(vecs[v].exp_count));
        end

        // Timeout with in_valid stalling every other cycle, pattern absent.
        do_cfg(8'b1111, 4'd4, 1'b1, 8'd0, 16'd10);
        done_cycle = 0;
        for (int c = 1; c <= 20; c++) begin
            in_valid = c[0];
            in_bit   = 1'b0;
            @(negedge clk);
            if (done) begin
                done_cycle = c;
                break;
            end
        end
        in_valid = 1'b0;
        chk("stall_done_cycle", 32'(done_cycle), 10);
        chk("stall_timed_out", 32'(timed_out), 1);
        chk("stall_count", 32'(match_count), 0);
        repeat (2) @(negedge clk);
        chk("stall_done_held", 32'({done, timed_out}), 32'(2'b11));
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        chk("stall_ack_idle", 32'({cfg_ready, done}), 32'(2'b10));

        // Abort on the cycle that would complete a second match.
        do_cfg(8'b1010, 4'd4, 1'b1, 8'd0, 16'd0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        chk("abort_first_det", 32'(detected), 1);
        send_bit(1);
        abort = 1'b1;
        send_bit(0);
        abort = 1'b0;
        chk("abort_no_det", 32'(detected), 0);
        chk("abort_count", 32'(match_count), 1);
        chk("abort_idle", 32'({cfg_ready, busy}), 32'(2'b10));

        // Illegal lengths: 0 and MAX_LEN+1.
        cfg_len = 4'd0; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("len0_err", 32'(cfg_err), 1);
        chk("len0_idle", 32'({cfg_ready, busy}), 32'(2'b10));
        chk("len0_count_kept", 32'(match_count), 1);
        @(negedge clk);
        chk("len0_err_pulse", 32'(cfg_err), 0);
        cfg_len = 4'd9; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("len9_err", 32'(cfg_err), 1);
        chk("len9_idle", 32'({cfg_ready, busy}), 32'(2'b10));
        @(negedge clk);
        chk("len9_err_pulse", 32'(cfg_err), 0);

        // Count saturation with a single-bit pattern.
        do_cfg(8'b1, 4'd1, 1'b1, 8'd0, 16'd0);
        last_det = 1'b0;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(negedge clk);
            last_det = detected;
        end
        in_valid = 1'b0;
        chk("sat_count", 32'(match_count), 255);
        chk("sat_det", 32'(last_det), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Asynchronous reset between clock edges in RUN.
        do_cfg(8'b1010, 4'd4, 1'b1, 8'd0, 16'd0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        chk("arst_pre_count", 32'(match_count), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cfg_ready", 32'(cfg_ready), 1);
        chk("arst_count", 32'(match_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_after", 32'({cfg_ready, busy, done}), 32'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_session_ctrl.md
Name: seq_detect_session_ctrl

Overview:
- Controller for a configurable serial-pattern detection session.
- A host loads a pattern of 1..MAX_LEN bits, a match target and a timeout. The block then accepts a serial bit stream through a valid/ready handshake and counts pattern occurrences, in overlapping or non-overlapping mode.
- A session ends on reaching the target, on timeout, or on host abort. On target or timeout, done is held until the host acknowledges.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match target and match counter.
- TMO_W, 16, width of timeout value and cycle timer.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  configuration accepted when high with cfg_valid.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_target  input  CNT_W  matches to end session; 0 means unlimited.
- cfg_timeout  input  TMO_W  session cycle limit; 0 means disabled.
- cfg_overlap  input  1  1 = overlapping matches counted.
- cfg_err  output  1  one-cycle pulse when an illegal cfg_len is offered.
- in_valid  input  1  stream bit valid.
- in_bit  input  1  stream bit.
- in_ready  output  1  stream bit accepted when high with in_valid.
- abort  input  1  terminate session, return to IDLE.
- detected  output  1  one-cycle match pulse.
- match_count  output  CNT_W  matches in current or last session.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- timed_out  output  1  valid while done; 1 = ended by timeout.
- done_ack  input  1  host acknowledge of done.

Behaviour:
- States: IDLE, RUN, DONE. Unused encodings go to IDLE.
- Combinational outputs from state: cfg_ready=1 in IDLE only; in_ready=1 and busy=1 in RUN only; done=1 in DONE only.
- Reset (async):
  - state=IDLE.
  - detected, cfg_err, match_count, timed_out, window, fill count and timer all cleared.
  - Hence cfg_ready=1 and all other outputs 0 immediately.
- IDLE:
  - Handshake with cfg_len in 1..MAX_LEN: latch all cfg fields, clear window, fill, timer, match_count and timed_out, then go to RUN.
  - Handshake with an illegal cfg_len (0 or >MAX_LEN): cfg_err pulses for one cycle, nothing is latched, state stays IDLE, match_count is retained.
  - abort and done_ack are ignored.
- RUN, per accepted bit (in_valid & in_ready):
  - new_window = {window, in_bit}; fill saturates at len.
  - A match occurs if (fill+1) >= len and new_window[len-1:0] == pattern[len-1:0].
  - On a match: detected=1 and match_count increments on the same edge, so detected is high the cycle after the final bit is accepted (latency 1).
  - match_count saturates at all-ones.
  - Non-overlap mode: a match resets fill to 0, so the next match needs len fresh bits. Overlap mode keeps fill.
  - No accepted bit means no window change and detected=0.
- RUN, timer:
  - Increments every RUN cycle regardless of in_valid.
  - If cfg_timeout≠0 and the timer reaches cfg_timeout-1: go to DONE with timed_out=1. RUN therefore lasts exactly cfg_timeout cycles.
- RUN, target:
  - If cfg_target≠0 and the match_count increment equals cfg_target: go to DONE with timed_out=0. detected still pulses for that match.
- RUN, priority on the same cycle: abort > target > timeout.
  - abort: go to IDLE immediately. A bit accepted that cycle is discarded, no detected pulse. match_count holds.
  - A target match coinciding with the timeout ends with timed_out=0 and the count including that match.
- DONE: match_count and timed_out hold. done_ack returns to IDLE next cycle. abort is also accepted and returns to IDLE.
- Back-to-back sessions: new configuration is possible in the first IDLE cycle after DONE.
- Reset mid-session: immediate return to IDLE, all state cleared.

Test Plan:
- Overlap count with a 6-bit pattern: pattern=110011, len=6, overlap=1, target=0, timeout=0. Stream 0011_0101_1001_1001_1010_1000 with in_valid continuous -> detected after bits idx 12 and 16, match_count=2; abort -> IDLE, count holds 2.
- Non-overlap, same pattern and stream, overlap=0 -> single detected after idx 12, match_count=1.
- 4-bit pattern: pattern=1010, len=4, overlap=1 on the same stream -> detected after idx 6, 19, 21, count=3. With overlap=0 -> after idx 6, 19, count=2.
- Target stop: pattern=1010, len=4, target=2, overlap=1, same stream -> detected after idx 19, then DONE with timed_out=0 and count=2; in_ready=0 afterwards; done_ack -> IDLE with cfg_ready=1.
- Timeout with stalls: timeout=10, in_valid toggling every other cycle, pattern never present -> done exactly 10 cycles after config, timed_out=1, count=0.
- Illegal configuration and async reset: cfg_len=0 -> cfg_err pulse, stays IDLE. cfg_len=9 -> same. Async rst asserted mid-RUN between clock edges -> busy=0 and cfg_ready=1 before the next edge, count=0.
